// File: rtl/mem_arbiter_2to1.sv
// Shares one memory worker between two requesters with a single outstanding transaction.
// Requesters alternate through a priority pointer; within a requester, a write goes before a read.
module mem_arbiter_2to1 #(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              r0_rd_valid,
  input  logic [ADDR_W-1:0] r0_rd_addr,
  output logic              r0_rd_ready,
  output logic [31:0]       r0_rd_data,
  input  logic              r0_wr_valid,
  input  logic [ADDR_W-1:0] r0_wr_addr,
  input  logic [31:0]       r0_wr_data,
  input  logic [3:0]        r0_wr_byteEn,
  output logic              r0_wr_ready,
  input  logic              r1_rd_valid,
  input  logic [ADDR_W-1:0] r1_rd_addr,
  output logic              r1_rd_ready,
  output logic [31:0]       r1_rd_data,
  input  logic              r1_wr_valid,
  input  logic [ADDR_W-1:0] r1_wr_addr,
  input  logic [31:0]       r1_wr_data,
  input  logic [3:0]        r1_wr_byteEn,
  output logic              r1_wr_ready,
  output logic              m_rd_valid,
  output logic [ADDR_W-1:0] m_rd_addr,
  input  logic              m_rd_ready,
  input  logic [31:0]       m_rd_data,
  output logic              m_wr_valid,
  output logic [ADDR_W-1:0] m_wr_addr,
  output logic [31:0]       m_wr_data,
  output logic [3:0]        m_wr_byteEn,
  input  logic              m_wr_ready
);

  typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, RESP, RELEASE} state_t;

  state_t state_q, state_d;
  logic   ptr_q;        // requester preferred when both request
  logic   sel_q;        // requester currently being served
  logic   served_wr_q;  // served transaction is a write

  logic              req0, req1, pick, pick_wr;
  logic              launch_wr, launch_rd, wr_done, rd_done, served_valid;
  logic [ADDR_W-1:0] pick_wr_addr, pick_rd_addr;
  logic [31:0]       pick_wr_data;
  logic [3:0]        pick_wr_be;

  assign req0 = r0_wr_valid | r0_rd_valid;
  assign req1 = r1_wr_valid | r1_rd_valid;
  // A lone requester wins regardless of the pointer.
  assign pick    = (req0 && req1) ? ptr_q : req1;
  assign pick_wr = pick ? r1_wr_valid : r0_wr_valid;

  assign pick_wr_addr = pick ? r1_wr_addr   : r0_wr_addr;
  assign pick_wr_data = pick ? r1_wr_data   : r0_wr_data;
  assign pick_wr_be   = pick ? r1_wr_byteEn : r0_wr_byteEn;
  assign pick_rd_addr = pick ? r1_rd_addr   : r0_rd_addr;

  // A selected write waits in IDLE for m_wr_ready rather than falling back to the read.
  assign launch_wr = (state_q == IDLE) && (req0 || req1) && pick_wr && m_wr_ready;
  assign launch_rd = (state_q == IDLE) && (req0 || req1) && !pick_wr;
  assign wr_done   = (state_q == WR_REQ) && m_wr_valid && m_wr_ready;
  assign rd_done   = (state_q == RD_REQ) && m_rd_ready;

  assign served_valid = sel_q ? (served_wr_q ? r1_wr_valid : r1_rd_valid)
                              : (served_wr_q ? r0_wr_valid : r0_rd_valid);

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (launch_wr)      state_d = WR_REQ;
        else if (launch_rd) state_d = RD_REQ;
      end
      WR_REQ:  if (wr_done) state_d = RESP;
      RD_REQ:  if (rd_done) state_d = RESP;
      RESP:    state_d = RELEASE;
      RELEASE: if (!served_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: read-data holding registers are reset too, so every output reads 0 during reset.
    if (!reset_n) begin
      ptr_q       <= 1'b0;
      sel_q       <= 1'b0;
      served_wr_q <= 1'b0;
      m_rd_valid  <= 1'b0;
      m_rd_addr   <= '0;
      m_wr_valid  <= 1'b0;
      m_wr_addr   <= '0;
      m_wr_data   <= '0;
      m_wr_byteEn <= '0;
      r0_rd_ready <= 1'b0;
      r0_wr_ready <= 1'b0;
      r0_rd_data  <= '0;
      r1_rd_ready <= 1'b0;
      r1_wr_ready <= 1'b0;
      r1_rd_data  <= '0;
    end else begin
      if (launch_wr) begin
        m_wr_valid  <= 1'b1;
        m_wr_addr   <= pick_wr_addr;
        m_wr_data   <= pick_wr_data;
        m_wr_byteEn <= pick_wr_be;
        sel_q       <= pick;
        served_wr_q <= 1'b1;
      end
      if (launch_rd) begin
        m_rd_valid  <= 1'b1;
        m_rd_addr   <= pick_rd_addr;
        sel_q       <= pick;
        served_wr_q <= 1'b0;
      end
      if (wr_done) begin
        m_wr_valid  <= 1'b0;
        r0_wr_ready <= ~sel_q;
        r1_wr_ready <= sel_q;
      end
      if (rd_done) begin
        m_rd_valid <= 1'b0;
        if (sel_q) begin
          r1_rd_data  <= m_rd_data;
          r1_rd_ready <= 1'b1;
        end else begin
          r0_rd_data  <= m_rd_data;
          r0_rd_ready <= 1'b1;
        end
      end
      if (state_q == RESP) begin
        r0_rd_ready <= 1'b0;
        r0_wr_ready <= 1'b0;
        r1_rd_ready <= 1'b0;
        r1_wr_ready <= 1'b0;
      end
      if ((state_q == RELEASE) && !served_valid) ptr_q <= ~sel_q;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Bench for mem_arbiter_2to1: behavioural memory worker, reference memory and an ordered
// scoreboard of expected ready pulses, driven by a vector table plus multi-cycle sequences.
module tb_mem_arbiter_2to1;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 40;

  logic clock = 1'b0;
  logic reset_n;
  logic              r0_rd_valid, r0_rd_ready, r0_wr_valid, r0_wr_ready;
  logic [ADDR_W-1:0] r0_rd_addr, r0_wr_addr;
  logic [31:0]       r0_rd_data, r0_wr_data;
  logic [3:0]        r0_wr_byteEn;
  logic              r1_rd_valid, r1_rd_ready, r1_wr_valid, r1_wr_ready;
  logic [ADDR_W-1:0] r1_rd_addr, r1_wr_addr;
  logic [31:0]       r1_rd_data, r1_wr_data;
  logic [3:0]        r1_wr_byteEn;
  logic              m_rd_valid, m_rd_ready, m_wr_valid, m_wr_ready;
  logic [ADDR_W-1:0] m_rd_addr, m_wr_addr;
  logic [31:0]       m_rd_data, m_wr_data;
  logic [3:0]        m_wr_byteEn;

  always #5 clock = ~clock;

  mem_arbiter_2to1 #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .r0_rd_valid(r0_rd_valid), .r0_rd_addr(r0_rd_addr), .r0_rd_ready(r0_rd_ready),
    .r0_rd_data(r0_rd_data), .r0_wr_valid(r0_wr_valid), .r0_wr_addr(r0_wr_addr),
    .r0_wr_data(r0_wr_data), .r0_wr_byteEn(r0_wr_byteEn), .r0_wr_ready(r0_wr_ready),
    .r1_rd_valid(r1_rd_valid), .r1_rd_addr(r1_rd_addr), .r1_rd_ready(r1_rd_ready),
    .r1_rd_data(r1_rd_data), .r1_wr_valid(r1_wr_valid), .r1_wr_addr(r1_wr_addr),
    .r1_wr_data(r1_wr_data), .r1_wr_byteEn(r1_wr_byteEn), .r1_wr_ready(r1_wr_ready),
    .m_rd_valid(m_rd_valid), .m_rd_addr(m_rd_addr), .m_rd_ready(m_rd_ready),
    .m_rd_data(m_rd_data), .m_wr_valid(m_wr_valid), .m_wr_addr(m_wr_addr),
    .m_wr_data(m_wr_data), .m_wr_byteEn(m_wr_byteEn), .m_wr_ready(m_wr_ready)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          id;
    bit          is_wr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int          id;
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          lat;
  } vec_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [0:63];
  logic [31:0] wmem    [0:63];
  logic        bd_we;
  logic [5:0]  bd_idx;
  logic [31:0] bd_data;
  int          wr_b2b    = 0;
  int          addr_errs = 0;
  logic        mwv_prev  = 1'b0;

  // Memory worker: writes accepted on the handshake edge, reads answered one cycle after m_rd_valid.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_rd_ready <= 1'b0;
      m_rd_data  <= '0;
    end else if (m_rd_ready) begin
      m_rd_ready <= 1'b0;
    end else if (m_rd_valid) begin
      m_rd_ready <= 1'b1;
      m_rd_data  <= wmem[m_rd_addr[7:2]];
    end
  end

  always @(posedge clock) begin
    if (bd_we) wmem[bd_idx] <= bd_data;
    else if (m_wr_valid && m_wr_ready)
      for (int b = 0; b < 4; b++)
        if (m_wr_byteEn[b]) wmem[m_wr_addr[7:2]][8*b +: 8] <= m_wr_data[8*b +: 8];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic on_pulse(input int id, input bit is_wr, input logic [31:0] data);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_pulse: r%0d is_wr=%0d with no transaction expected", id, is_wr);
    end else begin
      e = exp_q.pop_front();
      check("pulse_requester", 32'(id), 32'(e.id));
      check("pulse_kind", 32'(is_wr), 32'(e.is_wr));
      if (!is_wr) check("rd_data", data, e.data);
      if (id == 0) check("other_ready_low", {30'b0, r1_rd_ready, r1_wr_ready}, 32'h0);
      else         check("other_ready_low", {30'b0, r0_rd_ready, r0_wr_ready}, 32'h0);
    end
  endtask

  always @(negedge clock) begin
    if (r0_wr_ready) on_pulse(0, 1'b1, 32'h0);
    if (r0_rd_ready) on_pulse(0, 1'b0, r0_rd_data);
    if (r1_wr_ready) on_pulse(1, 1'b1, 32'h0);
    if (r1_rd_ready) on_pulse(1, 1'b0, r1_rd_data);
    // The worker is always ready during launches, so each write should hold m_wr_valid one cycle.
    if (mwv_prev && m_wr_valid && m_wr_ready) wr_b2b++;
    mwv_prev = m_wr_valid;
    if (m_rd_valid && (m_rd_addr[31:8] != 0 || m_rd_addr[1:0] != 0)) addr_errs++;
    if (m_wr_valid && (m_wr_addr[31:8] != 0 || m_wr_addr[1:0] != 0)) addr_errs++;
  end

  function automatic logic any_out();
    return r0_rd_ready | r0_wr_ready | (|r0_rd_data) | r1_rd_ready | r1_wr_ready | (|r1_rd_data)
         | m_rd_valid | m_wr_valid | (|m_rd_addr) | (|m_wr_addr) | (|m_wr_data) | (|m_wr_byteEn);
  endfunction

  function automatic logic ready_of(input int id, input bit is_wr);
    if (id == 0) return is_wr ? r0_wr_ready : r0_rd_ready;
    return is_wr ? r1_wr_ready : r1_rd_ready;
  endfunction

  task automatic expect_txn(input int id, input bit is_wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] be);
    exp_t e;
    int   idx;
    idx = int'(addr[7:2]);
    if (is_wr)
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
    e.id    = id;
    e.is_wr = is_wr;
    e.data  = is_wr ? 32'h0 : ref_mem[idx];
    exp_q.push_back(e);
  endtask

  task automatic drive_req(input int id, input bit is_wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be);
    if (id == 0) begin
      if (is_wr) begin
        r0_wr_addr = addr; r0_wr_data = data; r0_wr_byteEn = be; r0_wr_valid = 1'b1;
      end else begin
        r0_rd_addr = addr; r0_rd_valid = 1'b1;
      end
    end else begin
      if (is_wr) begin
        r1_wr_addr = addr; r1_wr_data = data; r1_wr_byteEn = be; r1_wr_valid = 1'b1;
      end else begin
        r1_rd_addr = addr; r1_rd_valid = 1'b1;
      end
    end
  endtask

  task automatic drop_req(input int id, input bit is_wr);
    if (id == 0) begin
      if (is_wr) r0_wr_valid = 1'b0; else r0_rd_valid = 1'b0;
    end else begin
      if (is_wr) r1_wr_valid = 1'b0; else r1_rd_valid = 1'b0;
    end
  endtask

  task automatic wait_pulse(input int id, input bit is_wr, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!ready_of(id, is_wr) && n < TIMEOUT);
    if (!ready_of(id, is_wr)) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: r%0d is_wr=%0d no pulse within %0d cycles", id, is_wr, TIMEOUT);
    end
  endtask

  // Full handshake, then two idle cycles so the arbiter has left RELEASE before the next request.
  task automatic do_req(input int id, input bit is_wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be, output int n);
    drive_req(id, is_wr, addr, data, be);
    wait_pulse(id, is_wr, n);
    drop_req(id, is_wr);
    repeat (2) @(negedge clock);
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    ref_mem[idx] = val;
    bd_idx  = 6'(idx);
    bd_data = val;
    bd_we   = 1'b1;
    @(negedge clock);
    bd_we   = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    int n, n0, n1;

    vecs[0] = '{id: 0, is_wr: 1'b1, addr: 32'h10, data: 32'hDEADBEEF, be: 4'hF, lat: 2};
    vecs[1] = '{id: 0, is_wr: 1'b0, addr: 32'h10, data: 32'h0,        be: 4'h0, lat: 3};
    vecs[2] = '{id: 1, is_wr: 1'b0, addr: 32'h08, data: 32'h0,        be: 4'h0, lat: 3};
    vecs[3] = '{id: 1, is_wr: 1'b1, addr: 32'h08, data: 32'h00001234, be: 4'h3, lat: 2};
    vecs[4] = '{id: 0, is_wr: 1'b0, addr: 32'h08, data: 32'h0,        be: 4'h0, lat: 3};
    vecs[5] = '{id: 1, is_wr: 1'b0, addr: 32'h24, data: 32'h0,        be: 4'h0, lat: 3};
    vecs[6] = '{id: 0, is_wr: 1'b1, addr: 32'h3C, data: 32'hAABBCCDD, be: 4'h9, lat: 2};
    vecs[7] = '{id: 1, is_wr: 1'b0, addr: 32'h3C, data: 32'h0,        be: 4'h0, lat: 3};

    reset_n = 1'b0;
    bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    r0_rd_valid = 1'b0; r0_rd_addr = '0; r0_wr_valid = 1'b0; r0_wr_addr = '0;
    r0_wr_data = '0; r0_wr_byteEn = '0;
    r1_rd_valid = 1'b0; r1_rd_addr = '0; r1_wr_valid = 1'b0; r1_wr_addr = '0;
    r1_wr_data = '0; r1_wr_byteEn = '0;
    m_wr_ready = 1'b1;

    @(negedge clock);
    for (int i = 0; i < 64; i++)
      preload(i, (i == 0) ? 32'h11111111 : (i == 1) ? 32'h22222222 :
                 (i == 2) ? 32'hFFFFFFFF : 32'h0);
    check("reset_outputs_zero", {31'b0, any_out()}, 32'h0);
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_outputs_zero", {31'b0, any_out()}, 32'h0);

    // Simultaneous reads after reset: pointer favours r0, then r1 is served.
    expect_txn(0, 1'b0, 32'h0, 32'h0, 4'h0);
    expect_txn(1, 1'b0, 32'h4, 32'h0, 4'h0);
    fork
      do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, n0);
      do_req(1, 1'b0, 32'h4, 32'h0, 4'h0, n1);
    join
    check("r0_first_latency", 32'(n0), 32'd3);
    check("r1_rd_data_after_both", r1_rd_data, 32'h22222222);
    check("r0_rd_data_unchanged", r0_rd_data, 32'h11111111);

    // Both requesters keep issuing writes: grants must alternate r0, r1, r0, ...
    for (int i = 0; i < 3; i++) begin
      expect_txn(0, 1'b1, 32'h20 + 32'(4*i), 32'hA0000000 + 32'(i), 4'hF);
      expect_txn(1, 1'b1, 32'h30 + 32'(4*i), 32'hB0000000 + 32'(i), 4'hF);
    end
    fork
      for (int i = 0; i < 3; i++) do_req(0, 1'b1, 32'h20 + 32'(4*i), 32'hA0000000 + 32'(i), 4'hF, n0);
      for (int i = 0; i < 3; i++) do_req(1, 1'b1, 32'h30 + 32'(4*i), 32'hB0000000 + 32'(i), 4'hF, n1);
    join

    for (int i = 0; i < 8; i++) begin
      expect_txn(vecs[i].id, vecs[i].is_wr, vecs[i].addr, vecs[i].data, vecs[i].be);
      do_req(vecs[i].id, vecs[i].is_wr, vecs[i].addr, vecs[i].data, vecs[i].be, n);
      check($sformatf("vec%0d_latency", i), 32'(n), 32'(vecs[i].lat));
    end

    // r1 raises read and write together: write first, read after re-arbitration.
    expect_txn(1, 1'b1, 32'h40, 32'h5A5A5A5A, 4'hF);
    expect_txn(1, 1'b0, 32'h40, 32'h0, 4'h0);
    drive_req(1, 1'b1, 32'h40, 32'h5A5A5A5A, 4'hF);
    drive_req(1, 1'b0, 32'h40, 32'h0, 4'h0);
    wait_pulse(1, 1'b1, n);
    check("rdwr_write_latency", 32'(n), 32'd2);
    drop_req(1, 1'b1);
    wait_pulse(1, 1'b0, n);
    check("rdwr_read_after_release", 32'(n), 32'd5);
    drop_req(1, 1'b0);
    repeat (2) @(negedge clock);

    // Write held off while the worker is not ready.
    expect_txn(0, 1'b1, 32'h44, 32'h01020304, 4'hF);
    m_wr_ready = 1'b0;
    drive_req(0, 1'b1, 32'h44, 32'h01020304, 4'hF);
    repeat (4) @(negedge clock);
    check("held_m_wr_valid_low", {31'b0, m_wr_valid}, 32'h0);
    m_wr_ready = 1'b1;
    wait_pulse(0, 1'b1, n);
    check("held_write_latency", 32'(n), 32'd2);
    drop_req(0, 1'b1);
    repeat (2) @(negedge clock);

    // Valid dropped mid-read: the transaction still completes with its pulse.
    expect_txn(1, 1'b0, 32'h44, 32'h0, 4'h0);
    drive_req(1, 1'b0, 32'h44, 32'h0, 4'h0);
    @(negedge clock);
    drop_req(1, 1'b0);
    wait_pulse(1, 1'b0, n);
    check("dropped_read_latency", 32'(n), 32'd2);
    repeat (2) @(negedge clock);

    // Reset during RD_REQ abandons the read without a pulse.
    check("pre_reset_r0_rd_data", r0_rd_data, 32'hFFFF1234);
    drive_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clock);
    check("in_rd_req_m_rd_valid", {31'b0, m_rd_valid}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("mid_reset_outputs_zero", {31'b0, any_out()}, 32'h0);
    check("mid_reset_r0_rd_data", r0_rd_data, 32'h0);
    drop_req(0, 1'b0);
    repeat (3) @(negedge clock);
    check("held_reset_outputs_zero", {31'b0, any_out()}, 32'h0);
    reset_n = 1'b1;
    @(negedge clock);
    expect_txn(0, 1'b0, 32'h10, 32'h0, 4'h0);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, n);
    check("post_reset_read_latency", 32'(n), 32'd3);
    repeat (3) @(negedge clock);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("m_wr_valid_back_to_back", 32'(wr_b2b), 32'd0);
    check("memory_address_aligned", 32'(addr_errs), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_2to1.md
MEM_ARBITER_2TO1 -- requirements
Module: mem_arbiter_2to1

Interface
REQ-001 Parameter ADDR_W, default 32, width of all address buses.
REQ-002 Ports: clock  in  1  sole clock; all state updates on rising edge.
REQ-003 Ports: reset_n  in  1  reset, asynchronous, active-low.
REQ-004 Ports (N = 0, 1): rN_rd_valid  in  1  read request, held until rN_rd_ready pulse.
REQ-005 Ports: rN_rd_addr  in  ADDR_W  read byte address, word-aligned.
REQ-006 Ports: rN_rd_ready  out  1  single-cycle read-complete pulse.
REQ-007 Ports: rN_rd_data  out  32  registered read data for requester N.
REQ-008 Ports: rN_wr_valid  in  1  write request, held until rN_wr_ready pulse.
REQ-009 Ports: rN_wr_addr  in  ADDR_W  / rN_wr_data  in  32  / rN_wr_byteEn  in  4  write address, data, byte enables.
REQ-010 Ports: rN_wr_ready  out  1  single-cycle write-complete pulse.
REQ-011 Ports: m_rd_valid, m_wr_valid  out  1; m_rd_addr, m_wr_addr  out  ADDR_W; m_wr_data  out  32; m_wr_byteEn  out  4  toward memory worker.
REQ-012 Ports: m_rd_ready, m_wr_ready  in  1; m_rd_data  in  32  from memory worker.

Function
REQ-013 The block SHALL share one memory worker between two requesters, with exactly one transaction outstanding at the memory at any time.
REQ-014 FSM states SHALL be IDLE, WR_REQ, RD_REQ, RESP, RELEASE.
REQ-015 In IDLE the block SHALL select a requester with rN_wr_valid or rN_rd_valid high; if both requesters request, the one indicated by a priority pointer wins.
REQ-016 Within the selected requester, write SHALL take precedence over read.
REQ-017 A write SHALL be launched only when m_wr_ready = 1; otherwise the block SHALL stay in IDLE for that selection.
REQ-018 On launch, the block SHALL register the winner's address, data and byte enables onto the m_* outputs, assert m_wr_valid or m_rd_valid, and enter WR_REQ or RD_REQ.
REQ-019 In WR_REQ, on the edge where m_wr_valid and m_wr_ready are both high, the block SHALL clear m_wr_valid, set rN_wr_ready, and enter RESP.
REQ-020 In RD_REQ, on the edge where m_rd_ready = 1, the block SHALL clear m_rd_valid, capture m_rd_data into rN_rd_data, set rN_rd_ready, and enter RESP.
REQ-021 Latency (request sampled at edge E): write ready pulse high during E+1..E+2, and read ready pulse high during E+2..E+3, with data valid in the same cycle.
REQ-022 RESP SHALL last exactly one cycle; it then clears the ready pulse and enters RELEASE.
REQ-023 RELEASE SHALL wait until the served requester's served valid is low, then enter IDLE and point the priority pointer at the other requester.
REQ-024 A requester that drops valid mid-transaction SHALL NOT abort it: the memory transaction completes and the pulse is still issued.
REQ-025 The non-selected requester SHALL see its ready outputs low and its rd_data unchanged.
REQ-026 rN_rd_data SHALL hold its last captured value until the next read response to requester N.
REQ-027 A single requester requesting alone SHALL be served regardless of the pointer.

Reset
REQ-028 While reset_n = 0, all outputs SHALL be 0, including both rN_rd_data, the state SHALL be IDLE, and the pointer SHALL be 0 (r0 preferred).
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction with no ready pulse issued; after release, operation resumes from IDLE.

Verification
REQ-030 r0 write addr 0x10, data 0xDEADBEEF, byteEn 0xF; then r0 read 0x10 -> r0_wr_ready pulse, then r0_rd_ready pulse with r0_rd_data = 0xDEADBEEF.
REQ-031 r0 and r1 request reads of 0x0 and 0x4 in the same cycle after reset -> r0 served first, r1 second; r1_rd_data correct and r0_rd_data unchanged.
REQ-032 Both requesters continuously request writes -> grants alternate r0, r1, r0, r1, and m_wr_valid is never high for two transactions back-to-back without m_wr_ready returning high.
REQ-033 r1 asserts rd_valid and wr_valid together -> write to memory first; the read is served after RELEASE and re-arbitration.
REQ-034 Write to 0x8 with byteEn 0x3 over 0xFFFFFFFF, data 0x00001234 -> readback 0xFFFF1234.
REQ-035 reset_n pulsed low during RD_REQ -> all outputs 0 immediately; no stale rd_ready pulse; the next read completes normally.
